lpm_tbl_access_ctrl: RTL and testbench

//  Owns the 32-entry LPM route table. Serialises software read, write and clear requests from the

---
 rtl/lpm_tbl_access_ctrl_pkg.sv | 35 +++
 rtl/lpm_tbl_access_ctrl_if.sv | 40 ++++
 rtl/lpm_tbl_access_ctrl_regfile.sv | 50 +++++
 rtl/lpm_tbl_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lpm_tbl_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpm_tbl_access_ctrl_pkg.sv
// Shared definitions for the LPM route table: sizes, entry field offsets
// and the state/operation encodings used by the access controller.
package lpm_pkg;

    localparam int C_S_AXI_DATA_WIDTH = 32;
    localparam int TBL_DEPTH          = 32;
    localparam int TBL_AW             = $clog2(TBL_DEPTH);
    localparam int ENTRY_W            = 4 * C_S_AXI_DATA_WIDTH;
    localparam int KEY_W              = 2 * C_S_AXI_DATA_WIDTH;
    localparam int FLAT_W             = TBL_DEPTH * KEY_W;

    // Field positions inside one 128-bit entry: {oq, nh, mask, ip}
    localparam int IP_LSB   = 0;
    localparam int MASK_LSB = 32;
    localparam int NH_LSB   = 64;
    localparam int OQ_LSB   = 96;

    localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(TBL_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CLEAR = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    // Which operation the ACK state is acknowledging
    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_CLR = 2'd2
    } op_t;

endpackage

// File: rtl/lpm_tbl_access_ctrl_if.sv
// Register-block / datapath side of the LPM table controller.
// Handshake: a *_req is sampled on every rising clock edge it is high; each
// accepted request is answered by exactly one single-cycle *_ack, and a
// request seen while an identical one is still waiting is dropped (counted
// in drop_count). tbl_rd_data is valid with tbl_rd_ack and holds afterwards.
interface lpm_tbl_access_ctrl_if;
    import lpm_pkg::*;

    logic                 tbl_rd_req;
    logic [TBL_AW-1:0]    tbl_rd_addr;
    logic [ENTRY_W-1:0]   tbl_rd_data;
    logic                 tbl_rd_ack;
    logic                 tbl_wr_req;
    logic [TBL_AW-1:0]    tbl_wr_addr;
    logic [ENTRY_W-1:0]   tbl_wr_data;
    logic                 tbl_wr_ack;
    logic                 tbl_clr_req;
    logic                 tbl_clr_ack;
    logic                 lookup_busy;
    logic [TBL_DEPTH-1:0] entry_valid;
    logic [FLAT_W-1:0]    lpm_key_flat;
    logic [FLAT_W-1:0]    lpm_result_flat;
    logic [31:0]          drop_count;
    state_t               dbg_state;

    modport slave (
        input  tbl_rd_req, tbl_rd_addr, tbl_wr_req, tbl_wr_addr, tbl_wr_data,
               tbl_clr_req, lookup_busy,
        output tbl_rd_data, tbl_rd_ack, tbl_wr_ack, tbl_clr_ack, entry_valid,
               lpm_key_flat, lpm_result_flat, drop_count, dbg_state
    );

    modport master (
        output tbl_rd_req, tbl_rd_addr, tbl_wr_req, tbl_wr_addr, tbl_wr_data,
               tbl_clr_req, lookup_busy,
        input  tbl_rd_data, tbl_rd_ack, tbl_wr_ack, tbl_clr_ack, entry_valid,
               lpm_key_flat, lpm_result_flat, drop_count, dbg_state
    );

endinterface

// File: rtl/lpm_tbl_access_ctrl_regfile.sv
// 32 x 128b route table with per-entry valid bits: one write port, one
// read port, and every entry fanned out in parallel for the lookup datapath.
module lpm_tbl_regfile
    import lpm_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic [TBL_AW-1:0]    i_waddr,
    input  logic [ENTRY_W-1:0]   i_wdata,
    input  logic                 i_wvalid,
    input  logic [TBL_AW-1:0]    i_raddr,
    output logic [ENTRY_W-1:0]   o_rdata,
    output logic [TBL_DEPTH-1:0] o_valid,
    output logic [FLAT_W-1:0]    o_key_flat,
    output logic [FLAT_W-1:0]    o_result_flat
);

    logic [ENTRY_W-1:0]   r_mem [TBL_DEPTH];
    logic [TBL_DEPTH-1:0] r_valid;

    // Entry storage: a single write per cycle updates data and valid together
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
        end else if (i_we) begin
            r_mem[i_waddr]   <= i_wdata;
            r_valid[i_waddr] <= i_wvalid;
        end
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_valid = r_valid;

    // Split every entry into the {mask, ip} key and {oq, nh} result lanes
    always_comb begin
        o_key_flat    = '0;
        o_result_flat = '0;
        for (int i = 0; i < TBL_DEPTH; i++) begin
            o_key_flat[i*KEY_W +: KEY_W]    = {r_mem[i][MASK_LSB +: C_S_AXI_DATA_WIDTH],
                                               r_mem[i][IP_LSB   +: C_S_AXI_DATA_WIDTH]};
            o_result_flat[i*KEY_W +: KEY_W] = {r_mem[i][OQ_LSB   +: C_S_AXI_DATA_WIDTH],
                                               r_mem[i][NH_LSB   +: C_S_AXI_DATA_WIDTH]};
        end
    end

endmodule

// File: rtl/lpm_tbl_access_ctrl.sv
// LPM route table access controller: latches software read/write/clear
// requests, arbitrates them (clear > write > read), keeps table updates away
// from an in-progress header lookup, and acknowledges each operation.
module lpm_tbl_access_ctrl
    import lpm_pkg::*;
(
    input  logic                  AXI_ACLK,
    input  logic                  AXI_RESETN,
    lpm_tbl_access_ctrl_if.slave  tbl
);

    state_t               r_state, w_next_state;
    op_t                  r_op;
    logic                 r_rd_pend, r_wr_pend, r_clr_pend;
    logic [TBL_AW-1:0]    r_rd_addr, r_wr_addr, r_op_addr, r_clr_idx;
    logic [ENTRY_W-1:0]   r_wr_data, r_op_data, r_rd_data;
    logic [31:0]          r_drop_count;

    logic                 w_idle, w_rd_elig, w_wr_elig, w_clr_elig;
    logic                 w_grant_rd, w_grant_wr, w_grant_clr;
    logic [TBL_AW-1:0]    w_rd_sel_addr, w_wr_sel_addr, w_waddr;
    logic [ENTRY_W-1:0]   w_wr_sel_data, w_wdata, w_rf_rdata;
    logic                 w_we, w_wvalid;
    logic                 w_rd_ack, w_wr_ack, w_clr_ack;
    logic [1:0]           w_drop_inc;
    logic [32:0]          w_drop_sum;

    // A request is eligible when it is pending or arriving this cycle;
    // updates wait for the datapath, reads never do.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_rd_elig   = r_rd_pend  | tbl.tbl_rd_req;
    assign w_wr_elig   = r_wr_pend  | tbl.tbl_wr_req;
    assign w_clr_elig  = r_clr_pend | tbl.tbl_clr_req;
    assign w_grant_clr = w_idle & w_clr_elig & ~tbl.lookup_busy;
    assign w_grant_wr  = w_idle & w_wr_elig & ~tbl.lookup_busy & ~w_clr_elig;
    assign w_grant_rd  = w_idle & w_rd_elig & ~w_grant_clr & ~w_grant_wr;

    assign w_rd_sel_addr = r_rd_pend ? r_rd_addr : tbl.tbl_rd_addr;
    assign w_wr_sel_addr = r_wr_pend ? r_wr_addr : tbl.tbl_wr_addr;
    assign w_wr_sel_data = r_wr_pend ? r_wr_data : tbl.tbl_wr_data;

    // State register
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) r_state <= ST_IDLE;
        else             r_state <= w_next_state;
    end

    // Next-state: one cycle per read/write, one entry per unblocked clear cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_clr)     w_next_state = ST_CLEAR;
                else if (w_grant_wr) w_next_state = ST_WRITE;
                else if (w_grant_rd) w_next_state = ST_READ;
            end
            ST_READ:  w_next_state = ST_ACK;
            ST_WRITE: w_next_state = ST_ACK;
            ST_CLEAR: begin
                if (!tbl.lookup_busy && (r_clr_idx == LAST_IDX)) w_next_state = ST_ACK;
            end
            ST_ACK:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs: table write port and the single-cycle acknowledges
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_op_addr;
        w_wdata   = r_op_data;
        w_wvalid  = 1'b0;
        w_rd_ack  = 1'b0;
        w_wr_ack  = 1'b0;
        w_clr_ack = 1'b0;
        case (r_state)
            ST_WRITE: begin
                w_we     = 1'b1;
                w_wvalid = 1'b1;
            end
            ST_CLEAR: begin
                w_we    = ~tbl.lookup_busy;
                w_waddr = r_clr_idx;
                w_wdata = '0;
            end
            ST_ACK: begin
                w_rd_ack  = (r_op == OP_RD);
                w_wr_ack  = (r_op == OP_WR);
                w_clr_ack = (r_op == OP_CLR);
            end
            default: ;
        endcase
    end

    // Pending flags: hold the first copy, clear on grant
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            r_rd_pend  <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_clr_pend <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            if (w_grant_rd) r_rd_pend <= 1'b0;
            else if (tbl.tbl_rd_req && !r_rd_pend) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= tbl.tbl_rd_addr;
            end
            if (w_grant_wr) r_wr_pend <= 1'b0;
            else if (tbl.tbl_wr_req && !r_wr_pend) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= tbl.tbl_wr_addr;
                r_wr_data <= tbl.tbl_wr_data;
            end
            if (w_grant_clr) r_clr_pend <= 1'b0;
            else if (tbl.tbl_clr_req && !r_clr_pend) r_clr_pend <= 1'b1;
        end
    end

    // Capture the granted operation and its operands
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            r_op      <= OP_RD;
            r_op_addr <= '0;
            r_op_data <= '0;
        end else if (w_grant_clr) begin
            r_op <= OP_CLR;
        end else if (w_grant_wr) begin
            r_op      <= OP_WR;
            r_op_addr <= w_wr_sel_addr;
            r_op_data <= w_wr_sel_data;
        end else if (w_grant_rd) begin
            r_op      <= OP_RD;
            r_op_addr <= w_rd_sel_addr;
        end
    end

    // Clear walk index: advances only on cycles where an entry was cleared
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN)                                  r_clr_idx <= '0;
        else if (r_state == ST_CLEAR && !tbl.lookup_busy) r_clr_idx <= r_clr_idx + 1'b1;
    end

    // Read data register: loaded in READ, held until the next read
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN)              r_rd_data <= '0;
        else if (r_state == ST_READ)  r_rd_data <= w_rf_rdata;
    end

    // Saturating count of requests dropped against an occupied pending slot
    assign w_drop_inc = 2'(tbl.tbl_rd_req & r_rd_pend) + 2'(tbl.tbl_wr_req & r_wr_pend)
                      + 2'(tbl.tbl_clr_req & r_clr_pend);
    assign w_drop_sum = {1'b0, r_drop_count} + {31'b0, w_drop_inc};

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN)        r_drop_count <= '0;
        else if (w_drop_sum[32]) r_drop_count <= '1;
        else                    r_drop_count <= w_drop_sum[31:0];
    end

    lpm_tbl_regfile u_regfile (
        .i_clk         (AXI_ACLK),
        .i_rst_n       (AXI_RESETN),
        .i_we          (w_we),
        .i_waddr       (w_waddr),
        .i_wdata       (w_wdata),
        .i_wvalid      (w_wvalid),
        .i_raddr       (r_op_addr),
        .o_rdata       (w_rf_rdata),
        .o_valid       (tbl.entry_valid),
        .o_key_flat    (tbl.lpm_key_flat),
        .o_result_flat (tbl.lpm_result_flat)
    );

    assign tbl.tbl_rd_data = r_rd_data;
    assign tbl.tbl_rd_ack  = w_rd_ack;
    assign tbl.tbl_wr_ack  = w_wr_ack;
    assign tbl.tbl_clr_ack = w_clr_ack;
    assign tbl.drop_count  = r_drop_count;
    assign tbl.dbg_state   = r_state;

endmodule

// File: tb/tb_lpm_tbl_access_ctrl.sv
// Bench for lpm_tbl_access_ctrl: table of single read/write vectors, then
// hand-written sequences for blocking, priority, drops, clear pause and reset.
module tb_lpm_tbl_access_ctrl;
  import lpm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lpm_tbl_access_ctrl_if tbl_if();

  lpm_tbl_access_ctrl dut (
    .AXI_ACLK   (clk),
    .AXI_RESETN (rst_n),
    .tbl        (tbl_if)
  );

  // ---------------- scoreboard ----------------
  localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_CLR = 2'd2;

  typedef struct packed {
    logic [1:0]         kind;
    logic [31:0]        cyc;
    logic [ENTRY_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]           op;
    logic [TBL_AW-1:0]    addr;
    logic [ENTRY_W-1:0]   data;
    int                   lat;
    logic [ENTRY_W-1:0]   exp_rd;
    logic [TBL_DEPTH-1:0] exp_valid;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_flat(input string name, input logic [FLAT_W-1:0] act,
                          input logic [FLAT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < TBL_DEPTH; i++) begin
        if (act[i*KEY_W +: KEY_W] !== exp[i*KEY_W +: KEY_W]) begin
          $display("FAIL %s: entry %0d got %h want %h", name, i,
                   act[i*KEY_W +: KEY_W], exp[i*KEY_W +: KEY_W]);
          break;
        end
      end
    end
  endtask

  task automatic push(input logic [1:0] kind, input int c, input logic [ENTRY_W-1:0] d);
    exp_t e;
    e.kind = kind;
    e.cyc  = 32'(c);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int bound);
    for (int t = 0; t < bound && exp_q.size() != 0; t++) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d acks outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle_inputs();
    tbl_if.tbl_rd_req  = 1'b0;
    tbl_if.tbl_wr_req  = 1'b0;
    tbl_if.tbl_clr_req = 1'b0;
  endtask

  // Ack monitor: each ack must match the head of the expected queue
  int         mon_n;
  logic [1:0] mon_k;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_n = int'(tbl_if.tbl_rd_ack) + int'(tbl_if.tbl_wr_ack) + int'(tbl_if.tbl_clr_ack);
      if (mon_n != 0) begin
        mon_k = tbl_if.tbl_rd_ack ? K_RD : (tbl_if.tbl_wr_ack ? K_WR : K_CLR);
        chk("ack_onehot", 128'(mon_n), 128'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got kind %0d at cycle %0d want none", mon_k, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_kind", 128'(mon_k), 128'(mon_e.kind));
          chk("ack_cycle", 128'(cyc), 128'(mon_e.cyc));
          if (mon_e.kind == K_RD) chk("rd_data", tbl_if.tbl_rd_data, mon_e.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [ENTRY_W-1:0] d3, d0, d31, d3b, d5, da, db, dc;
  logic [FLAT_W-1:0]  exp_flat;
  int c0;

  initial begin
    d3  = {32'h2, 32'h0A000001, 32'hFFFFFF00, 32'h0A000000};
    d0  = {32'h1, 32'hC0A80001, 32'hFFFF0000, 32'hC0A80000};
    d31 = {32'h8, 32'h0B0B0B01, 32'hFF000000, 32'h0B000000};
    d3b = {32'h4, 32'h0A000002, 32'hFFFFFFFF, 32'h0A000005};
    d5  = {$urandom, $urandom, $urandom, $urandom};
    da  = {$urandom, $urandom, $urandom, $urandom};
    db  = ~da;
    dc  = {32'($urandom_range(1, 15)), $urandom, $urandom, $urandom};

    vecs[0] = '{K_WR, 5'd3,  d3,  2, '0,  32'h0000_0008};
    vecs[1] = '{K_RD, 5'd3,  '0,  2, d3,  32'h0000_0008};
    vecs[2] = '{K_WR, 5'd0,  d0,  2, '0,  32'h0000_0009};
    vecs[3] = '{K_WR, 5'd31, d31, 2, '0,  32'h8000_0009};
    vecs[4] = '{K_RD, 5'd31, '0,  2, d31, 32'h8000_0009};
    vecs[5] = '{K_RD, 5'd7,  '0,  2, '0,  32'h8000_0009};
    vecs[6] = '{K_WR, 5'd3,  d3b, 2, '0,  32'h8000_0009};
    vecs[7] = '{K_RD, 5'd3,  '0,  2, d3b, 32'h8000_0009};
    vecs[8] = '{K_RD, 5'd0,  '0,  2, d0,  32'h8000_0009};

    idle_inputs();
    tbl_if.lookup_busy = 1'b0;
    tbl_if.tbl_rd_addr = '0;
    tbl_if.tbl_wr_addr = '0;
    tbl_if.tbl_wr_data = '0;

    // Reset values
    repeat (3) step();
    chk("rst_valid", 128'(tbl_if.entry_valid), 128'd0);
    chk("rst_rd_data", tbl_if.tbl_rd_data, 128'd0);
    chk("rst_acks", 128'({tbl_if.tbl_rd_ack, tbl_if.tbl_wr_ack, tbl_if.tbl_clr_ack}), 128'd0);
    chk("rst_drop", 128'(tbl_if.drop_count), 128'd0);
    chk("rst_state", 128'(tbl_if.dbg_state), 128'(ST_IDLE));
    chk_flat("rst_key", tbl_if.lpm_key_flat, '0);
    chk_flat("rst_result", tbl_if.lpm_result_flat, '0);
    rst_n = 1'b1;
    repeat (2) step();

    // Table of single unblocked operations
    for (int i = 0; i < NV; i++) begin
      step();
      c0 = cyc;
      if (vecs[i].op == K_WR) begin
        tbl_if.tbl_wr_req  = 1'b1;
        tbl_if.tbl_wr_addr = vecs[i].addr;
        tbl_if.tbl_wr_data = vecs[i].data;
        push(K_WR, c0 + vecs[i].lat, '0);
      end else begin
        tbl_if.tbl_rd_req  = 1'b1;
        tbl_if.tbl_rd_addr = vecs[i].addr;
        push(K_RD, c0 + vecs[i].lat, vecs[i].exp_rd);
      end
      step();
      idle_inputs();
      drain(20);
      chk("vec_valid", 128'(tbl_if.entry_valid), 128'(vecs[i].exp_valid));
      if (vecs[i].op == K_WR) begin
        chk("vec_key", 128'(tbl_if.lpm_key_flat[vecs[i].addr*KEY_W +: KEY_W]),
            128'(vecs[i].data[63:0]));
        chk("vec_result", 128'(tbl_if.lpm_result_flat[vecs[i].addr*KEY_W +: KEY_W]),
            128'(vecs[i].data[127:64]));
      end
      if (i == 0) chk("t1_result3", 128'(tbl_if.lpm_result_flat[255:192]),
                      128'({32'h2, 32'h0A000001}));
    end

    // Blocked write with a read behind it: read overtakes
    step();
    c0 = cyc;
    tbl_if.lookup_busy = 1'b1;
    tbl_if.tbl_wr_req  = 1'b1;
    tbl_if.tbl_wr_addr = 5'd5;
    tbl_if.tbl_wr_data = d5;
    tbl_if.tbl_rd_req  = 1'b1;
    tbl_if.tbl_rd_addr = 5'd3;
    push(K_RD, c0 + 2, d3b);
    push(K_WR, c0 + 8, '0);
    step();
    idle_inputs();
    while (cyc < c0 + 6) step();
    tbl_if.lookup_busy = 1'b0;
    drain(30);
    chk("t3_valid", 128'(tbl_if.entry_valid), 128'h8000_0029);
    chk("t3_result5", 128'(tbl_if.lpm_result_flat[5*KEY_W +: KEY_W]), 128'(d5[127:64]));

    // Second write while the first is held: dropped, first one committed
    step();
    c0 = cyc;
    tbl_if.lookup_busy = 1'b1;
    tbl_if.tbl_wr_req  = 1'b1;
    tbl_if.tbl_wr_addr = 5'd9;
    tbl_if.tbl_wr_data = da;
    push(K_WR, c0 + 6, '0);
    step();
    tbl_if.tbl_wr_data = db;
    step();
    idle_inputs();
    while (cyc < c0 + 4) step();
    tbl_if.lookup_busy = 1'b0;
    drain(30);
    chk("t5_drop", 128'(tbl_if.drop_count), 128'd1);
    chk("t5_key9", 128'(tbl_if.lpm_key_flat[9*KEY_W +: KEY_W]), 128'(da[63:0]));
    chk("t5_valid", 128'(tbl_if.entry_valid), 128'h8000_0229);
    step();
    c0 = cyc;
    tbl_if.tbl_rd_req  = 1'b1;
    tbl_if.tbl_rd_addr = 5'd9;
    push(K_RD, c0 + 2, da);
    step();
    idle_inputs();
    drain(20);

    // Clear with a 4-cycle lookup in the middle of the walk
    step();
    c0 = cyc;
    tbl_if.tbl_clr_req = 1'b1;
    push(K_CLR, c0 + 37, '0);
    step();
    idle_inputs();
    while (cyc < c0 + 10) step();
    tbl_if.lookup_busy = 1'b1;
    while (cyc < c0 + 14) step();
    tbl_if.lookup_busy = 1'b0;
    drain(60);
    chk("t6_valid", 128'(tbl_if.entry_valid), 128'd0);
    chk_flat("t6_key", tbl_if.lpm_key_flat, '0);
    chk_flat("t6_result", tbl_if.lpm_result_flat, '0);

    // Clear, write and read in the same cycle, write/read to the same index
    step();
    c0 = cyc;
    tbl_if.tbl_clr_req = 1'b1;
    tbl_if.tbl_wr_req  = 1'b1;
    tbl_if.tbl_wr_addr = 5'd12;
    tbl_if.tbl_wr_data = dc;
    tbl_if.tbl_rd_req  = 1'b1;
    tbl_if.tbl_rd_addr = 5'd12;
    push(K_CLR, c0 + 33, '0);
    push(K_WR,  c0 + 36, '0);
    push(K_RD,  c0 + 39, dc);
    step();
    idle_inputs();
    drain(80);
    chk("t4_valid", 128'(tbl_if.entry_valid), 128'(32'h1 << 12));
    exp_flat = '0;
    exp_flat[12*KEY_W +: KEY_W] = dc[63:0];
    chk_flat("t4_key", tbl_if.lpm_key_flat, exp_flat);
    exp_flat = '0;
    exp_flat[12*KEY_W +: KEY_W] = dc[127:64];
    chk_flat("t4_result", tbl_if.lpm_result_flat, exp_flat);
    repeat (4) step();
    chk("rd_data_hold", tbl_if.tbl_rd_data, dc);
    chk("drop_final", 128'(tbl_if.drop_count), 128'd1);

    // Reset in the middle of a clear walk: no ack, everything back to zero
    step();
    c0 = cyc;
    tbl_if.tbl_clr_req = 1'b1;
    step();
    idle_inputs();
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 128'(tbl_if.entry_valid), 128'd0);
    chk("abort_drop", 128'(tbl_if.drop_count), 128'd0);
    chk("abort_state", 128'(tbl_if.dbg_state), 128'(ST_IDLE));
    chk_flat("abort_key", tbl_if.lpm_key_flat, '0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (45) step();
    chk("abort_no_ack_pending", 128'(exp_q.size()), 128'd0);
    chk("abort_valid_after", 128'(tbl_if.entry_valid), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
